// File: rtl/conv_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_cnt_pkg
// Description : Shared types for the convolution position counter and the
//               conv control logic that consumes its flags.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_cnt_pkg;

    // Counter run state: IDLE waits for start, RUN walks the frame
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_e;

    localparam int c_DEFAULT_COL_W = 16;
    localparam int c_DEFAULT_ROW_W = 16;

endpackage : conv_cnt_pkg
`default_nettype wire

// File: rtl/axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : axis_counter
// Description : Single-axis strided index. Advances by stride on inc and
//               wraps to zero once the next index would reach the limit.
//               The last flag is computed one bit wider than the index so a
//               large stride near the top of the range cannot wrap falsely.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    input  logic [W-1:0] stride,
    output logic [W-1:0] index,
    output logic         last
);

    logic [W:0] w_sum;

    assign w_sum = {1'b0, index} + {1'b0, stride};
    assign last  = (w_sum >= {1'b0, limit});

    // Index register: clear beats inc, wrap to zero on the last position
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (inc) begin
            index <= last ? '0 : w_sum[W-1:0];
        end
    end

endmodule : axis_counter
`default_nettype wire

// File: rtl/frame_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_index_counter
// Description : Two-level column/row position counter walking a programmable
//               WIDTH x HEIGHT frame with programmable strides. Provides
//               first/last column, last row flags and row/frame done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_index_counter
    import conv_cnt_pkg::*;
#(
    parameter int COL_W = 16,
    parameter int ROW_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             step,
    input  logic [COL_W-1:0] cfg_width,
    input  logic [ROW_W-1:0] cfg_height,
    input  logic [COL_W-1:0] cfg_cstride,
    input  logic [ROW_W-1:0] cfg_rstride,
    output logic             busy,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             first_col,
    output logic             last_col,
    output logic             last_row,
    output logic             row_done,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] c_COL_ONE = COL_W'(1);
    localparam logic [ROW_W-1:0] c_ROW_ONE = ROW_W'(1);

    cnt_state_e       r_state;
    cnt_state_e       w_state_nxt;
    logic [COL_W-1:0] r_width;
    logic [ROW_W-1:0] r_height;
    logic [COL_W-1:0] r_cstride;
    logic [ROW_W-1:0] r_rstride;
    logic             r_row_done;
    logic             r_frame_done;
    logic             w_run;
    logic             w_launch;
    logic             w_step_ok;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_clear;

    assign w_run     = (r_state == RUN);
    // abort wins over start and step in the same cycle
    assign w_launch  = (r_state == IDLE) && start && !abort;
    assign w_step_ok = w_run && step && !abort;
    assign w_clear   = abort || w_launch;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: leave RUN on abort or on the step off the final position
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = RUN;
            RUN:     if (abort || (w_step_ok && w_col_last && w_row_last)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: flags are only meaningful while a frame is running
    always_comb begin
        busy      = w_run;
        first_col = w_run && (col == '0);
        last_col  = w_run && w_col_last;
        last_row  = w_run && w_row_last;
    end

    // Configuration latch on frame launch; zero fields clamp to one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width   <= c_COL_ONE;
            r_height  <= c_ROW_ONE;
            r_cstride <= c_COL_ONE;
            r_rstride <= c_ROW_ONE;
        end else if (w_launch) begin
            r_width   <= (cfg_width   == '0) ? c_COL_ONE : cfg_width;
            r_height  <= (cfg_height  == '0) ? c_ROW_ONE : cfg_height;
            r_cstride <= (cfg_cstride == '0) ? c_COL_ONE : cfg_cstride;
            r_rstride <= (cfg_rstride == '0) ? c_ROW_ONE : cfg_rstride;
        end
    end

    // Done pulses, registered so they appear the cycle after the wrapping step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_row_done   <= w_step_ok && w_col_last;
            r_frame_done <= w_step_ok && w_col_last && w_row_last;
        end
    end

    assign row_done   = r_row_done;
    assign frame_done = r_frame_done;

    axis_counter #(
        .W (COL_W)
    ) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .inc    (w_step_ok),
        .limit  (r_width),
        .stride (r_cstride),
        .index  (col),
        .last   (w_col_last)
    );

    axis_counter #(
        .W (ROW_W)
    ) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .inc    (w_step_ok && w_col_last),
        .limit  (r_height),
        .stride (r_rstride),
        .index  (row),
        .last   (w_row_last)
    );

endmodule : frame_index_counter
`default_nettype wire
